coherent_dcache: RTL

Direct-mapped, write-back L1 data cache for one core of the dual-core MSI system, sitting directly upstream of the coherence controller. It serves datapath loads and stores with a single-cycle hit and drives this core's slice of the cache-control bus: block fills, dirty evictions, S→M upgrades and snoop responses. On halt it writes back every Modified block, then asserts `flushed`.

---
 rtl/coherent_dcache.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/coherent_dcache.sv
// Direct-mapped write-back L1 D-cache (MSI) for one core, 2-word blocks.
// Latency: hits complete in the request cycle; clean miss RD0+RD1, dirty miss adds WB0+WB1.
// Backpressure: every bus word waits for dwait low; snoops (ccwait) suspend RD0/WB0 and IDLE.
// Ports: CLK/nRST; datapath dmemREN/dmemWEN/dmemaddr/dmemstore/halt -> dhit/dmemload/flushed;
//        bus dREN/dWEN/daddr/dstore <- dload/dwait; coherence cctrans/ccwrite <- ccwait/ccinv/ccsnoopaddr.
module coherent_dcache #(
    parameter int SETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 29 - IW;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, RD0, RD1, UPG, SNP0, SNP1, FLUSH, FWB0, FWB1, DONE
    } state_t;

    state_t state, next;

    logic [SETS-1:0] valid, dirty;
    logic [TW-1:0]   tag [SETS];
    logic [31:0]     w0  [SETS];
    logic [31:0]     w1  [SETS];

    // Block address (addr[31:3]) of the outstanding miss/upgrade and of the snoop being serviced.
    logic [28:0]     blk_addr;
    logic [28:0]     snp_blk;
    logic [31:0]     fill0;
    logic [IW-1:0]   flush_idx;

    logic [IW-1:0]   req_idx, blk_idx, s_idx, snp_idx;
    logic [TW-1:0]   req_tag, blk_tag, s_tag;
    logic            req_off, req_match, s_tag_eq, s_hit_m, flush_last;
    logic            unused_bits;

    assign req_idx    = dmemaddr[2+IW:3];
    assign req_tag    = dmemaddr[31:3+IW];
    assign req_off    = dmemaddr[2];
    assign req_match  = valid[req_idx] && (tag[req_idx] == req_tag);
    assign blk_idx    = blk_addr[IW-1:0];
    assign blk_tag    = blk_addr[28:IW];
    assign s_idx      = ccsnoopaddr[2+IW:3];
    assign s_tag      = ccsnoopaddr[31:3+IW];
    assign s_tag_eq   = (tag[s_idx] == s_tag);
    assign s_hit_m    = valid[s_idx] && dirty[s_idx] && s_tag_eq;
    assign snp_idx    = snp_blk[IW-1:0];
    assign flush_last = (flush_idx == IW'(SETS - 1));
    assign flushed    = (state == DONE);
    assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};

    // Stores only hit in M; a store to S must first go through UPG.
    assign dhit = (state == IDLE) && !halt && !ccwait &&
                  ((dmemREN && req_match) || (dmemWEN && req_match && dirty[req_idx]));
    assign dmemload = dhit ? (req_off ? w1[req_idx] : w0[req_idx]) : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next    = state;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = 32'h0;
        dstore  = 32'h0;
        cctrans = 1'b0;
        ccwrite = 1'b0;
        case (state)
            IDLE: begin
                if (ccwait) begin
                    if (s_hit_m) begin
                        cctrans = 1'b1;
                        next    = SNP0;
                    end
                end else if (halt) begin
                    next = FLUSH;
                end else if (dmemWEN && req_match && !dirty[req_idx]) begin
                    next = UPG;
                end else if ((dmemREN || dmemWEN) && !req_match) begin
                    next = (valid[req_idx] && dirty[req_idx]) ? WB0 : RD0;
                end
            end
            WB0, WB1: begin
                // A snoop arriving before the first word moves preempts the miss.
                if (state == WB0 && ccwait && dwait) begin
                    if (s_hit_m) begin
                        cctrans = 1'b1;
                        next    = SNP0;
                    end
                end else begin
                    dWEN    = 1'b1;
                    cctrans = 1'b1;
                    daddr   = {tag[blk_idx], blk_idx, state == WB1, 2'b00};
                    dstore  = (state == WB1) ? w1[blk_idx] : w0[blk_idx];
                    if (!dwait) next = (state == WB1) ? RD0 : WB1;
                end
            end
            RD0, RD1: begin
                if (state == RD0 && ccwait && dwait) begin
                    if (s_hit_m) begin
                        cctrans = 1'b1;
                        next    = SNP0;
                    end
                end else begin
                    dREN    = 1'b1;
                    cctrans = 1'b1;
                    ccwrite = dmemWEN;
                    daddr   = {blk_addr, state == RD1, 2'b00};
                    if (!dwait) next = (state == RD1) ? IDLE : RD1;
                end
            end
            UPG: begin
                cctrans = 1'b1;
                next    = IDLE;
            end
            SNP0, SNP1: begin
                dWEN    = 1'b1;
                cctrans = 1'b1;
                daddr   = {snp_blk, state == SNP1, 2'b00};
                dstore  = (state == SNP1) ? w1[snp_idx] : w0[snp_idx];
                if (!dwait) next = (state == SNP1) ? IDLE : SNP1;
            end
            FLUSH: begin
                if (ccwait) begin
                    if (s_hit_m) begin
                        cctrans = 1'b1;
                        next    = SNP0;
                    end
                end else if (valid[flush_idx] && dirty[flush_idx]) begin
                    next = FWB0;
                end else if (flush_last) begin
                    next = DONE;
                end
            end
            FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = {tag[flush_idx], flush_idx, state == FWB1, 2'b00};
                dstore = (state == FWB1) ? w1[flush_idx] : w0[flush_idx];
                if (!dwait) begin
                    if (state == FWB0)   next = FWB1;
                    else if (flush_last) next = DONE;
                    else                 next = FLUSH;
                end
            end
            DONE:    next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= '0;
            dirty     <= '0;
            blk_addr  <= '0;
            snp_blk   <= '0;
            fill0     <= '0;
            flush_idx <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag[i] <= '0;
                w0[i]  <= '0;
                w1[i]  <= '0;
            end
        end else begin
            if (state == IDLE) blk_addr <= dmemaddr[31:3];
            if (state != SNP0 && state != SNP1) snp_blk <= ccsnoopaddr[31:3];
            if (dhit && dmemWEN) begin
                if (req_off) w1[req_idx] <= dmemstore;
                else         w0[req_idx] <= dmemstore;
            end
            case (state)
                UPG: dirty[blk_idx] <= 1'b1;
                WB1: if (!dwait) dirty[blk_idx] <= 1'b0;
                // Word 0 is buffered so the old line stays intact until the fill completes.
                RD0: if (!dwait) fill0 <= dload;
                RD1: if (!dwait) begin
                    w0[blk_idx]    <= fill0;
                    w1[blk_idx]    <= dload;
                    tag[blk_idx]   <= blk_tag;
                    valid[blk_idx] <= 1'b1;
                    dirty[blk_idx] <= 1'b0;
                end
                SNP1: if (!dwait) dirty[snp_idx] <= 1'b0;
                FLUSH: if (!ccwait && !(valid[flush_idx] && dirty[flush_idx]) && !flush_last)
                    flush_idx <= flush_idx + 1'b1;
                FWB1: if (!dwait) begin
                    dirty[flush_idx] <= 1'b0;
                    if (!flush_last) flush_idx <= flush_idx + 1'b1;
                end
                default: ;
            endcase
            // Invalidation wins over everything except the block mid-fill.
            if (ccinv && s_tag_eq && !(state == RD1 && s_idx == blk_idx))
                valid[s_idx] <= 1'b0;
        end
    end
endmodule
